// File: rtl/sync_count_driver_pkg.sv
// Shared types and constants for the synchronous driver of the NCL up/down
// counter: FSM state encoding, direction codes, default sizing and the
// ring-position arithmetic used by the position mirror.
package sync_count_driver_pkg;

    // Handshake phases of one count request.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // rails NULL, waiting for a command
        DATA  = 2'd1,   // one rail asserted, waiting for its completion
        NULLW = 2'd2,   // rails back to NULL, waiting for completion to clear
        ERR   = 2'd3    // protocol or timeout error, waiting for err_clr
    } state_e;

    // Direction codes carried on cmd_dir.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Default sizing.
    localparam int RAILS_DEFAULT   = 6;
    localparam int TIMEOUT_DEFAULT = 255;

    // Width of the mirrored position; covers the largest legal ring of 8.
    localparam int POS_W = 3;

    // Next ring position after one step in the given direction.
    function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos,
                                                  input logic             dir,
                                                  input int               rails);
        logic [POS_W-1:0] last;
        last = POS_W'(rails - 1);
        if (dir == DIR_UP) begin
            return (pos == last) ? '0 : pos + POS_W'(1);
        end
        return (pos == '0) ? last : pos - POS_W'(1);
    endfunction

    // True when a step in the given direction crosses the ring seam.
    function automatic logic pos_wraps(input logic [POS_W-1:0] pos,
                                       input logic             dir,
                                       input int               rails);
        if (dir == DIR_UP) begin
            return pos == POS_W'(rails - 1);
        end
        return pos == '0;
    endfunction

endpackage : sync_count_driver_pkg

// File: rtl/comp_sync.sv
// Two-flop synchronizer for one completion input coming back from the
// asynchronous NCL counter. With BYPASS set the raw input is passed straight
// through (same-domain simulation); the flops then have no load and are
// trimmed by synthesis.
module comp_sync #(
    parameter bit BYPASS = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [1:0] sync_d;
    logic [1:0] sync_q;

    // Shift the raw input into the two-stage chain.
    always_comb begin
        sync_d = {sync_q[0], async_in};
    end

    // Synchronizer chain register, cleared while reset is held.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = BYPASS ? async_in : sync_q[1];

endmodule : comp_sync

// File: rtl/sync_count_driver.sv
// Synchronous driver for a one-hot NCL up/down counter. Each accepted command
// raises one DATA rail, waits for the matching completion, returns the rails
// to NULL, waits for completion to clear and then advances a mirrored copy of
// the counter position. Wrong-rail completions and stalled handshakes raise a
// sticky error that only err_clr (with the counter quiet) can clear.
//
// Build option: define COMP_SYNC_EN to pass both completion inputs through a
// 2-flop synchronizer; leave it undefined to sample them directly when the
// counter model runs in the same clock domain.
module sync_count_driver
    import sync_count_driver_pkg::*;
#(
    parameter int RAILS          = RAILS_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             cmd_valid,
    input  logic             cmd_dir,
    output logic             cmd_ready,
    output logic             countup,
    output logic             countdn,
    input  logic             countupCOMP,
    input  logic             countdnCOMP,
    output logic [POS_W-1:0] pos,
    output logic             wrap,
    output logic             err,
    input  logic             err_clr
);

    // Wait counter must hold TIMEOUT_CYCLES itself without overflowing.
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

`ifdef COMP_SYNC_EN
    localparam bit SYNC_BYPASS = 1'b0;
`else
    localparam bit SYNC_BYPASS = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Completion inputs brought into the clock domain
    // ------------------------------------------------------------------
    logic up_comp_s;
    logic dn_comp_s;

    comp_sync #(.BYPASS(SYNC_BYPASS)) u_sync_up (
        .clk      (clk),
        .rst_n    (init_n),
        .async_in (countupCOMP),
        .sync_out (up_comp_s)
    );

    comp_sync #(.BYPASS(SYNC_BYPASS)) u_sync_dn (
        .clk      (clk),
        .rst_n    (init_n),
        .async_in (countdnCOMP),
        .sync_out (dn_comp_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_d,  state_q;
    logic              dir_d,    dir_q;
    logic [WAIT_W-1:0] wait_d,   wait_q;
    logic [POS_W-1:0]  pos_d,    pos_q;
    logic              wrap_d,   wrap_q;
    logic              err_d,    err_q;
    logic              up_d,     up_q;
    logic              dn_d,     dn_q;
    logic              run_d,    run_q;

    logic comp_clear;
    logic match_comp;
    logic opp_comp;
    logic timed_out;

    assign comp_clear = !up_comp_s && !dn_comp_s;
    assign match_comp = (dir_q == DIR_UP) ? up_comp_s : dn_comp_s;
    assign opp_comp   = (dir_q == DIR_UP) ? dn_comp_s : up_comp_s;
    assign timed_out  = wait_q >= WAIT_W'(TIMEOUT_CYCLES);

    // run_q holds cmd_ready off until the first edge after reset releases,
    // since IDLE with quiet completions would otherwise look ready in reset.
    assign cmd_ready = run_q && (state_q == IDLE) && !err_q && comp_clear;

    // Next-state, wait counter, position mirror and rail decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d = state_q;
        dir_d   = dir_q;
        wait_d  = wait_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        run_d   = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = DATA;
                    dir_d   = cmd_dir;
                    wait_d  = '0;
                end
            end

            DATA: begin
                if (opp_comp) begin
                    // Counter acknowledged the rail we did not drive.
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (match_comp) begin
                    state_d = NULLW;
                    wait_d  = '0;
                end else if (timed_out) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            NULLW: begin
                if (comp_clear) begin
                    state_d = IDLE;
                    pos_d   = pos_step(pos_q, dir_q, RAILS);
                    wrap_d  = pos_wraps(pos_q, dir_q, RAILS);
                end else if (timed_out) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ERR: begin
                // Leave only once the counter has gone quiet, so the next
                // command starts from a clean NULL handshake.
                if (err_clr && comp_clear) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Rails follow the next state so they change on the same edge as the
        // FSM; they can only be high in DATA and never both at once.
        up_d = (state_d == DATA) && (dir_d == DIR_UP);
        dn_d = (state_d == DATA) && (dir_d == DIR_DN);
    end

    // All driver state, returned to IDLE/NULL asynchronously by init_n.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            wait_q  <= '0;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            wait_q  <= wait_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            run_q   <= run_d;
        end
    end

    assign countup = up_q;
    assign countdn = dn_q;
    assign pos     = pos_q;
    assign wrap    = wrap_q;
    assign err     = err_q;

    // The two rails must never be DATA together.
    a_rails_exclusive : assert property (@(posedge clk) disable iff (!init_n)
        !(countup && countdn));

endmodule : sync_count_driver

// File: doc/sync_count_driver.md
SYNC_COUNT_DRIVER -- requirements
Module: sync_count_driver

Interface
REQ-001 Parameter RAILS, default 6: one-hot ring size of the up/down counter being driven; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum clocks spent in any handshake wait state before an error is flagged.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 init_n  in  1  reset, asynchronous and active-low.
REQ-005 cmd_valid  in  1  a count request is presented.
REQ-006 cmd_dir  in  1  1 = count up, 0 = count down; sampled with cmd_valid.
REQ-007 cmd_ready  out  1  the block accepts a command this cycle.
REQ-008 countup  out  1  up-rail DATA toward the NCL counter.
REQ-009 countdn  out  1  down-rail DATA toward the NCL counter.
REQ-010 countupCOMP  in  1  up-rail completion from the counter; asynchronous.
REQ-011 countdnCOMP  in  1  down-rail completion from the counter; asynchronous.
REQ-012 pos  out  3  mirrored counter position, 0..RAILS-1.
REQ-013 wrap  out  1  one-cycle pulse when pos wraps, either RAILS-1->0 or 0->RAILS-1.
REQ-014 err  out  1  sticky protocol or timeout error.
REQ-015 err_clr  in  1  clears err.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, DATA, NULLW, ERR.
REQ-017 IDLE: cmd_ready = 1 only when both synchronized COMP inputs are 0 and err = 0.
REQ-018 Acceptance: on cmd_valid & cmd_ready at edge N, the selected rail SHALL be high from edge N+1; go to DATA.
REQ-019 countup and countdn SHALL be registered, never high together, and both 0 (NULL) outside DATA.
REQ-020 DATA: when the matching synchronized COMP is seen high, drop the rail to NULL on the next edge; go to NULLW.
REQ-021 NULLW: when both synchronized COMP inputs are 0, update pos, pulse wrap if applicable, and return to IDLE.
  - pos update: up -> pos+1 mod RAILS; down -> pos-1 mod RAILS.
REQ-022 Minimum command-to-command spacing is 3 cycles plus 2x the synchronizer depth plus the counter response time.
REQ-023 In DATA, a high COMP on the opposite rail SHALL set err and move the FSM to ERR.
REQ-024 A per-state wait counter exceeding TIMEOUT_CYCLES in DATA or NULLW SHALL set err and move the FSM to ERR.
REQ-025 ERR: both rails NULL, cmd_ready = 0, pos held. On err_clr with both COMP inputs 0, clear err and go to IDLE.
REQ-026 If err_clr and an error event occur in the same cycle, the error wins (err stays 1).
REQ-027 cmd_valid outside IDLE SHALL be ignored; no command is queued.

Reset
REQ-028 While init_n = 0, regardless of the handshake phase:
  - FSM = IDLE; pos = 0; countup = countdn = 0; wrap = err = 0; cmd_ready = 0; all synchronizer flops = 0.
REQ-029 cmd_ready SHALL become eligible on the first edge after init_n rises.
REQ-030 A command in flight when reset asserts is abandoned; the counter is expected to be reinitialised by its own init.

Configuration
REQ-031 Macro COMP_SYNC_EN:
  - defined: countupCOMP and countdnCOMP each pass through a 2-flop synchronizer (depth 2).
  - undefined: COMP inputs are sampled directly (depth 0), for same-domain simulation only.
  - The FSM is identical in both cases.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the direction constants (DIR_UP = 1, DIR_DN = 0), and the default RAILS/TIMEOUT_CYCLES constants.
REQ-033 Sub-module comp_sync (2-flop synchronizer, async active-low reset) SHALL be instantiated once per COMP input.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - Reset, then one up command with the counter model acknowledging -> pos = 1, wrap = 0, rails NULL, cmd_ready = 1.
  - Six up commands from pos 0 -> pos = 0, with wrap pulsed exactly once, on the sixth.
  - One down command from pos 0 -> pos = 5, wrap pulsed once.
  - Model raises countdnCOMP during an up command -> err = 1, FSM in ERR, pos unchanged; err_clr -> err = 0, cmd_ready = 1.
  - Model never acknowledges, TIMEOUT_CYCLES = 16 -> err set 17 cycles after DATA is entered; rails NULL.
  - init_n pulsed low while in NULLW -> all outputs at reset values within the same cycle, pos = 0.
